// File: rtl/alu_8bit.sv
// 8-bit ALU: add, subtract, multiply and five bitwise ops behind a single output register stage.
// Produces a 16-bit result, a carry/borrow flag and a zero flag one cycle after in_valid.
module alu_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  select,
    input  logic        in_valid,
    output logic [15:0] result,
    output logic        carry,
    output logic        zflag,
    output logic        out_valid
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_XOR  = 3'b111
    } opcode_t;

    opcode_t     op;
    logic [8:0]  sum;
    logic [8:0]  diff;
    logic [15:0] prod;
    logic [15:0] nextres;
    logic        nextcarry;
    logic        nextzero;

    // The 9-bit subtraction wraps below zero, so its top bit is exactly the borrow (A < B).
    assign op   = opcode_t'(select);
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {8'h00, A} * {8'h00, B};

    always_comb begin
        nextres   = 16'h0000;
        nextcarry = 1'b0;
        case (op)
            OP_ADD: begin
                nextres   = {8'h00, sum[7:0]};
                nextcarry = sum[8];
            end
            OP_SUB: begin
                nextres   = {8'h00, diff[7:0]};
                nextcarry = diff[8];
            end
            OP_MUL:  nextres = prod;
            OP_AND:  nextres = {8'h00, A & B};
            OP_OR:   nextres = {8'h00, A | B};
            OP_NAND: nextres = ~{8'h00, A & B};
            OP_NOR:  nextres = ~{8'h00, A | B};
            OP_XOR:  nextres = {8'h00, A ^ B};
            default: nextres = 16'h0000;
        endcase
    end

    assign nextzero = (nextres == 16'h0000);

    // Idle cycles keep the last result and flags; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= 16'h0000;
            carry     <= 1'b0;
            zflag     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            result    <= nextres;
            carry     <= nextcarry;
            zflag     <= nextzero;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit: reset, opcode sweep, carry/borrow,
// multiply extremes, hold behaviour, back-to-back ops and reset mid-stream.
module tb_alu_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  select;
    logic        in_valid;
    logic [15:0] result;
    logic        carry;
    logic        zflag;
    logic        out_valid;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  sel;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    alu_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .select    (select),
        .in_valid  (in_valid),
        .result    (result),
        .carry     (carry),
        .zflag     (zflag),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so outputs are sampled well clear of it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] sel, input logic valid, input logic r);
        A        = a;
        B        = b;
        select   = sel;
        in_valid = valid;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(8'hFF, 8'h01, 3'b000, 1'b1, 1'b1);
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_result got %h want 0000", result);
        end
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_carry got %b want 0", carry);
        end
        checks++;
        if (zflag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_zflag got %b want 0", zflag);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_opcode_sweep();
        vec_t v[8];
        v[0] = '{8'h55, 8'hAA, 3'b000, 16'h00FF, 1'b0, 1'b0};
        v[1] = '{8'hAA, 8'h55, 3'b001, 16'h0055, 1'b0, 1'b0};
        v[2] = '{8'h55, 8'hAA, 3'b010, 16'h3872, 1'b0, 1'b0};
        v[3] = '{8'h55, 8'hAA, 3'b011, 16'h0000, 1'b0, 1'b1};
        v[4] = '{8'h55, 8'hAA, 3'b100, 16'h00FF, 1'b0, 1'b0};
        v[5] = '{8'h55, 8'hAA, 3'b101, 16'hFFFF, 1'b0, 1'b0};
        v[6] = '{8'h55, 8'hAA, 3'b110, 16'hFF00, 1'b0, 1'b0};
        v[7] = '{8'h55, 8'hAA, 3'b111, 16'h00FF, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(v[i].a, v[i].b, v[i].sel, 1'b1, 1'b0);
            checks++;
            if (result !== v[i].res || carry !== v[i].c || zflag !== v[i].z || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sweep[%0d] sel=%b got res=%h c=%b z=%b ov=%b want res=%h c=%b z=%b ov=1",
                         i, v[i].sel, result, carry, zflag, out_valid, v[i].res, v[i].c, v[i].z);
            end
        end
    endtask

    task automatic test_carry();
        vec_t v[5];
        v[0] = '{8'hFF, 8'h01, 3'b000, 16'h0000, 1'b1, 1'b1};
        v[1] = '{8'h00, 8'h01, 3'b001, 16'h00FF, 1'b1, 1'b0};
        v[2] = '{8'h7F, 8'h7F, 3'b001, 16'h0000, 1'b0, 1'b1};
        v[3] = '{8'hFF, 8'hFF, 3'b101, 16'hFF00, 1'b0, 1'b0};
        v[4] = '{8'h00, 8'h00, 3'b110, 16'hFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(v[i].a, v[i].b, v[i].sel, 1'b1, 1'b0);
            checks++;
            if (result !== v[i].res || carry !== v[i].c || zflag !== v[i].z) begin
                errors++;
                $display("[TB] FAIL carry[%0d] sel=%b got res=%h c=%b z=%b want res=%h c=%b z=%b",
                         i, v[i].sel, result, carry, zflag, v[i].res, v[i].c, v[i].z);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v[4];
        v[0] = '{8'hFF, 8'hFF, 3'b010, 16'hFE01, 1'b0, 1'b0};
        v[1] = '{8'h00, 8'hAB, 3'b010, 16'h0000, 1'b0, 1'b1};
        v[2] = '{8'h10, 8'h10, 3'b010, 16'h0100, 1'b0, 1'b0};
        v[3] = '{8'hCD, 8'h00, 3'b010, 16'h0000, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v[i].a, v[i].b, v[i].sel, 1'b1, 1'b0);
            checks++;
            if (result !== v[i].res || carry !== v[i].c || zflag !== v[i].z) begin
                errors++;
                $display("[TB] FAIL mul[%0d] got res=%h c=%b z=%b want res=%h c=%b z=%b",
                         i, result, carry, zflag, v[i].res, v[i].c, v[i].z);
            end
        end
    endtask

    task automatic test_hold();
        // F0+20 overflows, so a held carry of 1 is distinguishable from a recompute.
        applyStimulus(8'hF0, 8'h20, 3'b000, 1'b1, 1'b0);
        checks++;
        if (result !== 16'h0010 || carry !== 1'b1 || zflag !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_load got res=%h c=%b z=%b ov=%b want res=0010 c=1 z=0 ov=1",
                     result, carry, zflag, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h33 + 8'(i), 8'h33 + 8'(i), 3'b001, 1'b0, 1'b0);
            checks++;
            if (result !== 16'h0010 || carry !== 1'b1 || zflag !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold[%0d] got res=%h c=%b z=%b ov=%b want res=0010 c=1 z=0 ov=0",
                         i, result, carry, zflag, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[5];
        v[0] = '{8'h0F, 8'hF0, 3'b111, 16'h00FF, 1'b0, 1'b0};
        v[1] = '{8'h05, 8'h09, 3'b001, 16'h00FC, 1'b1, 1'b0};
        v[2] = '{8'h00, 8'h00, 3'b100, 16'h0000, 1'b0, 1'b1};
        v[3] = '{8'h80, 8'h80, 3'b000, 16'h0000, 1'b1, 1'b1};
        v[4] = '{8'hF0, 8'h3C, 3'b011, 16'h0030, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(v[i].a, v[i].b, v[i].sel, 1'b1, 1'b0);
            checks++;
            if (result !== v[i].res || carry !== v[i].c || zflag !== v[i].z || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] got res=%h c=%b z=%b ov=%b want res=%h c=%b z=%b ov=1",
                         i, result, carry, zflag, out_valid, v[i].res, v[i].c, v[i].z);
            end
        end
        applyStimulus(8'hFF, 8'hFF, 3'b010, 1'b1, 1'b1);
        checks++;
        if (result !== 16'h0000 || carry !== 1'b0 || zflag !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset got res=%h c=%b z=%b ov=%b want res=0000 c=0 z=0 ov=0",
                     result, carry, zflag, out_valid);
        end
        applyStimulus(8'h03, 8'h07, 3'b010, 1'b1, 1'b0);
        checks++;
        if (result !== 16'h0015 || carry !== 1'b0 || zflag !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset got res=%h c=%b z=%b ov=%b want res=0015 c=0 z=0 ov=1",
                     result, carry, zflag, out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
        select   = 3'b000;
        @(negedge clk);
        test_reset();
        test_opcode_sweep();
        test_carry();
        test_mul();
        test_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
